hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Producer side of operand forwarding for the 5-stage core. Tracks the destination tag (valid, 3-bit register, load flag) of every in-flight instruction through EX, ME and WB, and drives the `me_valid/me_rdst/wb_valid/wb_rdst` signals consumed by the forwarding mux select logic. Detects load-use hazards that forwarding cannot resolve and inserts bubbles. Honours memory-stall freeze and branch flush.

## Interface

Parameters:
- `REG_W`, 3 — register index width.
- `CNT_W`, 16 — width of the load-stall performance counter.

Ports:
- `clk`  in  1 — single clock; all state updates on the rising edge.
- `rst_n`  in  1 — synchronous, active-low reset.
- `id_valid`  in  1 — decode stage holds a real instruction.
- `id_rsrc1`, `id_rsrc2`  in  REG_W — source registers of the instruction in ID.
- `id_use1`, `id_use2`  in  1 — the corresponding source is actually read.
- `id_wen`  in  1 — the instruction in ID writes a register.
- `id_rdst`  in  REG_W — destination register of the instruction in ID.
- `id_is_load`  in  1 — the instruction in ID is a load.
- `mem_stall`  in  1 — data memory is busy; the whole pipeline freezes.
- `flush`  in  1 — a branch resolved in EX; wrong-path instructions in ID/EX are killed.
- `stall`  out  1 — hold PC and the IF/ID register.
- `bubble`  out  1 — load a NOP into ID/EX this cycle.
- `me_valid`  out  1 — ME holds a forwardable (non-load) result.
- `me_rdst`  out  REG_W — destination register of the ME stage.
- `wb_valid`  out  1 — WB holds a register write.
- `wb_rdst`  out  REG_W — destination register of the WB stage.
- `load_stall_cnt`  out  CNT_W — saturating count of load-use bubble cycles.

## Operation

- State: three tag slots.
  - EX slot: `{v, rdst, ld}`.
  - ME slot: `{v, rdst, ld}`.
  - WB slot: `{v, rdst}`.
  - Plus the counter.
- Hit definition: the ID instruction hits a slot when `id_valid`, the slot is valid with `ld=1`, and (`id_use1 && id_rsrc1==slot.rdst`) or (`id_use2 && id_rsrc2==slot.rdst`). Register 0 is not special-cased.
- `load_hazard`: a hit against the EX slot or against the ME slot.
  - A load's ME-stage value is its address, not its data.
  - A consumer therefore waits until the load reaches WB. That is 2 bubbles for a back-to-back use and 1 bubble with one independent instruction between.
- Priority, highest first:
  1. **`mem_stall`**
     - All slots and the counter hold.
     - `stall=1`, `bubble=0`.
     - `flush` is ignored; the branch unit holds `flush` until `mem_stall` drops.
  2. **`flush`**
     - WB←ME and ME←EX.
     - EX slot becomes invalid; the ID instruction is discarded.
     - `stall=0`, `bubble=1`.
     - No hazard stall is applied and the counter is unchanged.
  3. **`load_hazard`**
     - WB←ME and ME←EX.
     - EX slot becomes invalid.
     - `stall=1`, `bubble=1`.
     - Counter +1, saturating at all-ones.
  4. **Normal**
     - WB←ME and ME←EX.
     - EX←`{id_valid && id_wen, id_rdst, id_is_load && id_valid && id_wen}`.
     - `stall=0`, `bubble=0`.
- Outputs:
  - `me_valid = ME.v && !ME.ld`; `me_rdst = ME.rdst`.
  - `wb_valid = WB.v`; `wb_rdst = WB.rdst`.
  - A load in WB is forwarded normally.
- Invalid slots keep their `rdst` value. Consumers must gate on `valid`.

## Timing

- Reset (while `rst_n=0` at a rising edge):
  - All slot valid and load bits clear; all `rdst` fields 0; counter 0.
  - Hence `me_valid=0`, `me_rdst=0`, `wb_valid=0`, `wb_rdst=0`, `load_stall_cnt=0`.
  - `stall`/`bubble` are 0 provided `mem_stall=0` and `flush=0`.
- Reset wins over every other input. Reset mid-stall drops all in-flight tags; the first post-reset cycle behaves as an empty pipeline.
- `me_*`, `wb_*` and `load_stall_cnt` come straight from registers.
- `stall` and `bubble` are combinational from the ID inputs, `mem_stall`, `flush` and registered slot state, and are valid in the same cycle.
- Tag latency: an instruction accepted in ID at edge n is in EX after n, in ME after n+1, in WB after n+2, and gone after n+3. Each `mem_stall` cycle adds 1.
- Simultaneous events:
  - `mem_stall` with `load_hazard`: freeze only; no bubble and no count.
  - `flush` with `load_hazard`: flush only.
- The counter stays at saturation, with no wrap.

## Structure

- A shared package `pipe_pkg` holds:
  - the `REG_W` constant;
  - the `tag_t` struct `{v, rdst, ld}`;
  - the forward-select encodings `NOF=2'b00`, `MEF=2'b10`, `WBF=2'b11`, shared with the forwarding select logic.
- One sub-module `tag_hit` (combinational): compares the ID sources against one `tag_t`. It is instantiated for the EX and ME slots.
- The slot registers, priority mux and counter live in the top module.

## Test plan

- Reset, then `lw r3` followed immediately by `add r1,r3,r2` (use1): `stall=bubble=1` for exactly 2 cycles, `load_stall_cnt=2`, and `wb_valid=1, wb_rdst=3` in the cycle the add enters EX.
- `lw r3`, an independent op, then a consumer of r3: 1 bubble and counter +1. An `add` writing r5 shows `me_valid=1, me_rdst=5` one cycle after leaving EX.
- Consumer with `id_use1=0` matching a load's `rdst`: no stall, counter unchanged.
- `mem_stall` held for 3 cycles while a load is in EX and a dependent op is in ID:
  - outputs are frozen, `stall=1`, `bubble=0`, counter unchanged;
  - the 2-bubble sequence then resumes after release.
- `flush` while a load-use hazard is present:
  - `bubble=1`, `stall=0`, counter unchanged;
  - the EX tag invalid next cycle.
- Preload the counter to `CNT_W`'1 via repeated hazards: it stays at all-ones. Asserting `rst_n=0` for one edge mid-stall clears all outputs to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: destination tags and
// forwarding select encodings.
package pipe_pkg;

  localparam int REG_W = 3;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rdst;
    logic             ld;
  } tag_t;

  localparam logic [1:0] NOF = 2'b00;
  localparam logic [1:0] MEF = 2'b10;
  localparam logic [1:0] WBF = 2'b11;

endpackage

// File: rtl/hazard_scoreboard_tag_hit.sv
// Compares the ID sources against one in-flight
// tag; hits only on a valid load destination.
module tag_hit
  import pipe_pkg::*;
(
  input  logic             id_valid,
  input  tag_t             slot,
  input  logic [REG_W-1:0] rsrc1,
  input  logic [REG_W-1:0] rsrc2,
  input  logic             use1,
  input  logic             use2,
  output logic             hit
);

  logic m1;
  logic m2;

  // source match against an unresolved load
  always_comb begin
    m1  = use1 && (rsrc1 == slot.rdst);
    m2  = use2 && (rsrc2 == slot.rdst);
    hit = id_valid && slot.v && slot.ld
       && (m1 || m2);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Destination-tag scoreboard for EX/ME/WB with
// load-use bubble insertion and stall counter.
module hazard_scoreboard #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rsrc1,
  input  logic [REG_W-1:0] id_rsrc2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_wen,
  input  logic [REG_W-1:0] id_rdst,
  input  logic             id_is_load,
  input  logic             mem_stall,
  input  logic             flush,
  output logic             stall,
  output logic             bubble,
  output logic             me_valid,
  output logic [REG_W-1:0] me_rdst,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rdst,
  output logic [CNT_W-1:0] load_stall_cnt
);

  import pipe_pkg::*;

  tag_t             ex_q, ex_d;
  tag_t             me_q, me_d;
  logic             wb_v_q, wb_v_d;
  logic [REG_W-1:0] wb_rdst_q, wb_rdst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_ex;
  logic             hit_me;
  logic             load_hazard;

  tag_hit u_hit_ex (
    .id_valid (id_valid),
    .slot     (ex_q),
    .rsrc1    (id_rsrc1),
    .rsrc2    (id_rsrc2),
    .use1     (id_use1),
    .use2     (id_use2),
    .hit      (hit_ex)
  );

  tag_hit u_hit_me (
    .id_valid (id_valid),
    .slot     (me_q),
    .rsrc1    (id_rsrc1),
    .rsrc2    (id_rsrc2),
    .use1     (id_use1),
    .use2     (id_use2),
    .hit      (hit_me)
  );

  assign load_hazard = hit_ex || hit_me;

  // priority: freeze > flush > load bubble > advance
  always_comb begin
    ex_d      = ex_q;
    me_d      = me_q;
    wb_v_d    = wb_v_q;
    wb_rdst_d = wb_rdst_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    bubble    = 1'b0;
    if (mem_stall) begin
      stall = 1'b1;
    end else begin
      wb_v_d    = me_q.v;
      wb_rdst_d = me_q.rdst;
      me_d      = ex_q;
      if (flush) begin
        bubble  = 1'b1;
        ex_d.v  = 1'b0;
        ex_d.ld = 1'b0;
      end else if (load_hazard) begin
        stall   = 1'b1;
        bubble  = 1'b1;
        ex_d.v  = 1'b0;
        ex_d.ld = 1'b0;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
      end else begin
        ex_d.v    = id_valid && id_wen;
        ex_d.rdst = id_rdst;
        ex_d.ld   = id_is_load && id_valid
                 && id_wen;
      end
    end
  end

  // slot and counter registers, sync reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q      <= '0;
      me_q      <= '0;
      wb_v_q    <= 1'b0;
      wb_rdst_q <= '0;
      cnt_q     <= '0;
    end else begin
      ex_q      <= ex_d;
      me_q      <= me_d;
      wb_v_q    <= wb_v_d;
      wb_rdst_q <= wb_rdst_d;
      cnt_q     <= cnt_d;
    end
  end

  assign me_valid       = me_q.v && !me_q.ld;
  assign me_rdst        = me_q.rdst;
  assign wb_valid       = wb_v_q;
  assign wb_rdst        = wb_rdst_q;
  assign load_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an
// in-flight instruction list model.
module tb_hazard_scoreboard;

  localparam int RW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rsrc1 = '0;
  logic [RW-1:0] id_rsrc2 = '0;
  logic          id_use1 = 1'b0;
  logic          id_use2 = 1'b0;
  logic          id_wen = 1'b0;
  logic [RW-1:0] id_rdst = '0;
  logic          id_is_load = 1'b0;
  logic          mem_stall = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic          bubble;
  logic          me_valid;
  logic [RW-1:0] me_rdst;
  logic          wb_valid;
  logic [RW-1:0] wb_rdst;
  logic [CW-1:0] load_stall_cnt;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  hazard_scoreboard #(.REG_W(RW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_rsrc1       (id_rsrc1),
    .id_rsrc2       (id_rsrc2),
    .id_use1        (id_use1),
    .id_use2        (id_use2),
    .id_wen         (id_wen),
    .id_rdst        (id_rdst),
    .id_is_load     (id_is_load),
    .mem_stall      (mem_stall),
    .flush          (flush),
    .stall          (stall),
    .bubble         (bubble),
    .me_valid       (me_valid),
    .me_rdst        (me_rdst),
    .wb_valid       (wb_valid),
    .wb_rdst        (wb_rdst),
    .load_stall_cnt (load_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  // model: in-flight list, index 0 = youngest (EX)
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } inst_t;

  inst_t fl[3];
  int    mcnt;

  function automatic bit m_haz();
    bit h = 0;
    for (int k = 0; k < 2; k++) begin
      if (id_valid && fl[k].v && fl[k].ld &&
          ((id_use1 && int'(id_rsrc1) == fl[k].rd) ||
           (id_use2 && int'(id_rsrc2) == fl[k].rd)))
        h = 1;
    end
    return h;
  endfunction

  always @(posedge clk) begin
    bit h;
    h = m_haz();
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) fl[k] = '{0, 0, 0};
      mcnt = 0;
    end else if (!mem_stall) begin
      fl[2] = fl[1];
      fl[1] = fl[0];
      if (flush || h) begin
        fl[0].v  = 0;
        fl[0].ld = 0;
      end else begin
        fl[0].v  = id_valid && id_wen;
        fl[0].rd = int'(id_rdst);
        fl[0].ld = id_valid && id_wen && id_is_load;
      end
      if (!flush && h && mcnt < (1 << CW) - 1)
        mcnt = mcnt + 1;
    end
  end

  always @(negedge clk) begin
    bit h;
    if (chk_en) begin
      h = m_haz();
      chk("stall", int'(stall),
          int'(mem_stall || (!flush && h)));
      chk("bubble", int'(bubble),
          int'(!mem_stall && (flush || h)));
      chk("me_valid", int'(me_valid),
          int'(fl[1].v && !fl[1].ld));
      chk("me_rdst", int'(me_rdst), fl[1].rd);
      chk("wb_valid", int'(wb_valid), int'(fl[2].v));
      chk("wb_rdst", int'(wb_rdst), fl[2].rd);
      chk("cnt", int'(load_stall_cnt), mcnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    id_valid = 0; id_use1 = 0; id_use2 = 0;
    id_wen = 0; id_is_load = 0;
    id_rsrc1 = 0; id_rsrc2 = 0; id_rdst = 0;
  endtask

  task automatic ld(int rd);
    idle();
    id_valid = 1; id_wen = 1; id_is_load = 1;
    id_rdst = RW'(rd);
  endtask

  task automatic op(int s1, bit u1, int s2, bit u2, int rd);
    idle();
    id_valid = 1; id_wen = 1;
    id_rsrc1 = RW'(s1); id_use1 = u1;
    id_rsrc2 = RW'(s2); id_use2 = u2;
    id_rdst = RW'(rd);
  endtask

  task automatic sb(string nm, bit s, bit b);
    #1;
    chk({nm, "_stall"}, int'(stall), int'(s));
    chk({nm, "_bubble"}, int'(bubble), int'(b));
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick();
    tick();
    #1;
    chk("rst_me_valid", int'(me_valid), 0);
    chk("rst_me_rdst", int'(me_rdst), 0);
    chk("rst_wb_valid", int'(wb_valid), 0);
    chk("rst_wb_rdst", int'(wb_rdst), 0);
    chk("rst_cnt", int'(load_stall_cnt), 0);
    sb("rst", 0, 0);
    rst_n = 1;
    chk_en = 1;

    // lw r3 ; add r1,r3,r2
    ld(3);         sb("lw3", 0, 0);  tick();
    op(3, 1, 2, 1, 1);
    sb("use_b1", 1, 1); tick();
    sb("use_b2", 1, 1); tick();
    sb("use_go", 0, 0);
    chk("use_wb_valid", int'(wb_valid), 1);
    chk("use_wb_rdst", int'(wb_rdst), 3);
    chk("use_cnt", int'(load_stall_cnt), 2);
    tick();

    // lw r4 ; add r5 ; use r4
    ld(4);         tick();
    op(6, 1, 0, 0, 5);
    sb("indep", 0, 0);
    chk("fwd_me_valid", int'(me_valid), 1);
    chk("fwd_me_rdst", int'(me_rdst), 1);
    tick();
    op(0, 0, 4, 1, 6);
    sb("gap_b", 1, 1);
    chk("ld_me_hidden", int'(me_valid), 0);
    tick();
    sb("gap_go", 0, 0);
    chk("add5_me_valid", int'(me_valid), 1);
    chk("add5_me_rdst", int'(me_rdst), 5);
    chk("gap_cnt", int'(load_stall_cnt), 3);
    tick();

    // matching rdst but source not read
    ld(2);         tick();
    op(2, 0, 7, 1, 1);
    sb("nouse", 0, 0);
    tick();
    #1 chk("nouse_cnt", int'(load_stall_cnt), 3);

    // freeze with load in EX and consumer in ID
    ld(7);         tick();
    op(7, 1, 0, 0, 2);
    mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      sb("frz", 1, 0);
      chk("frz_cnt", int'(load_stall_cnt), 3);
      chk("frz_me_valid", int'(me_valid), 1);
      chk("frz_me_rdst", int'(me_rdst), 1);
      tick();
    end
    mem_stall = 0;
    sb("rel_b1", 1, 1); tick();
    sb("rel_b2", 1, 1); tick();
    sb("rel_go", 0, 0);
    chk("rel_cnt", int'(load_stall_cnt), 5);
    tick();

    // flush beats load hazard
    ld(1);         tick();
    op(1, 1, 0, 0, 6);
    flush = 1;
    sb("fl", 0, 1);
    tick();
    flush = 0;
    idle();
    #1 chk("fl_cnt", int'(load_stall_cnt), 5);
    tick();
    #1 chk("fl_ex_dead", int'(me_valid), 0);
    tick();

    // drive counter to saturation and beyond
    for (int r = 0; r < 6; r++) begin
      ld(3);       tick();
      op(3, 1, 3, 1, 4);
      tick(); tick(); tick();
    end
    #1 chk("sat_cnt", int'(load_stall_cnt), 15);

    // reset in the middle of a bubble
    ld(3);         tick();
    op(3, 1, 0, 0, 4);
    sb("pre_rst", 1, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    sb("post_rst", 0, 0);
    chk("prst_me_valid", int'(me_valid), 0);
    chk("prst_me_rdst", int'(me_rdst), 0);
    chk("prst_wb_valid", int'(wb_valid), 0);
    chk("prst_wb_rdst", int'(wb_rdst), 0);
    chk("prst_cnt", int'(load_stall_cnt), 0);
    tick();
    idle();
    tick();
    tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
